// File: rtl/seq_serializer_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : seq_serializer_if                                                |
// | Brief   : Word handshake and serial-bit bundle for seq_serializer.         |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+

interface seq_serializer_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] i_data;
    logic              i_vld;
    logic              o_rdy;
    logic              i_en;
    logic              o_seq;
    logic              o_seq_vld;
    logic              o_busy;

    modport master (
        output i_data, i_vld, i_en,
        input  o_rdy, o_seq, o_seq_vld, o_busy
    );

    modport slave (
        input  i_data, i_vld, i_en,
        output o_rdy, o_seq, o_seq_vld, o_busy
    );
endinterface

`default_nettype wire

// File: rtl/seq_serializer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : seq_serializer                                                   |
// | Brief   : Parallel-to-serial stage with a one-entry hold register feeding  |
// |           the sequence detector; optional even parity via macro            |
// |           SEQ_SERIALIZER_PARITY_EN.                                        |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+

module seq_serializer #(
    parameter int DATA_W    = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  wire              i_clk,
    input  wire              i_rst,
    seq_serializer_if.slave  bus
);

`ifdef SEQ_SERIALIZER_PARITY_EN
    localparam int LAST_I = DATA_W;
`else
    localparam int LAST_I = DATA_W - 1;
`endif
    localparam int                 CNT_W    = $clog2(LAST_I + 1);
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(LAST_I);
    localparam logic [CNT_W-1:0]   CNT_ONE  = CNT_W'(1);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   shreg_q, shreg_d;
    logic [DATA_W-1:0]   hold_q, hold_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                hold_full_q, hold_full_d;
    logic                rdy_en_q, rdy_en_d;
`ifdef SEQ_SERIALIZER_PARITY_EN
    logic                par_q, par_d;
`endif

    logic                w_rdy;
    logic                w_accept;
    logic                w_last;
    logic                w_data_bit;
    logic [DATA_W-1:0]   w_shifted;
    logic                w_load;
    logic [DATA_W-1:0]   w_load_word;

    // rdy_en_q keeps o_rdy low until the first edge after reset is released.
    assign w_rdy      = rdy_en_q & ~hold_full_q & ~i_rst;
    assign w_accept   = bus.i_vld & w_rdy;
    assign w_last     = (state_q == S_SHIFT) & bus.i_en & (cnt_q == CNT_LAST);
    assign w_data_bit = MSB_FIRST ? shreg_q[DATA_W-1] : shreg_q[0];
    assign w_shifted  = MSB_FIRST ? (shreg_q << 1) : (shreg_q >> 1);

    always_comb begin
        state_d     = state_q;
        shreg_d     = shreg_q;
        hold_d      = hold_q;
        cnt_d       = cnt_q;
        hold_full_d = hold_full_q;
        rdy_en_d    = 1'b1;
        w_load      = 1'b0;
        w_load_word = bus.i_data;
`ifdef SEQ_SERIALIZER_PARITY_EN
        par_d       = par_q;
`endif

        case (state_q)
            S_IDLE: begin
                w_load = w_accept;
            end
            S_SHIFT: begin
                if (w_last) begin
                    // Held word wins; o_rdy is low whenever hold is full, so no clash.
                    if (hold_full_q) begin
                        w_load      = 1'b1;
                        w_load_word = hold_q;
                        hold_full_d = 1'b0;
                    end else if (w_accept) begin
                        w_load      = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                        shreg_d = '0;
                        cnt_d   = '0;
                    end
                end else begin
                    if (bus.i_en) begin
                        shreg_d = w_shifted;
                        cnt_d   = cnt_q + CNT_ONE;
                    end
                    if (w_accept) begin
                        hold_d      = bus.i_data;
                        hold_full_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (w_load) begin
            state_d = S_SHIFT;
            shreg_d = w_load_word;
            cnt_d   = '0;
`ifdef SEQ_SERIALIZER_PARITY_EN
            par_d   = ^w_load_word;
`endif
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q     <= S_IDLE;
            shreg_q     <= '0;
            hold_q      <= '0;
            cnt_q       <= '0;
            hold_full_q <= 1'b0;
            rdy_en_q    <= 1'b0;
`ifdef SEQ_SERIALIZER_PARITY_EN
            par_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            hold_q      <= hold_d;
            cnt_q       <= cnt_d;
            hold_full_q <= hold_full_d;
            rdy_en_q    <= rdy_en_d;
`ifdef SEQ_SERIALIZER_PARITY_EN
            par_q       <= par_d;
`endif
        end
    end

    assign bus.o_rdy     = w_rdy;
    assign bus.o_seq_vld = (state_q == S_SHIFT);
    assign bus.o_busy    = (state_q == S_SHIFT) | hold_full_q;
`ifdef SEQ_SERIALIZER_PARITY_EN
    assign bus.o_seq     = (state_q == S_SHIFT) & ((cnt_q == CNT_LAST) ? par_q : w_data_bit);
`else
    assign bus.o_seq     = (state_q == S_SHIFT) & w_data_bit;
`endif

endmodule

`default_nettype wire
